// File: rtl/fetch_pc_unit.sv
// Program counter and instruction buffer: issues predict-not-taken sequential fetches,
// queues returned words tagged with their address, and redirects/drains on taken branches.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0100,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_valid,
  output logic        branch_ready,
  input  logic        branch_nia_valid,
  input  logic [31:0] branch_nia,
  output logic        fetch_req_valid,
  input  logic        fetch_req_ready,
  output logic [31:0] fetch_addr,
  input  logic        fetch_rsp_valid,
  input  logic [31:0] fetch_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_cia
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_SUM  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   tail_cia_reg, tail_cia_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

  logic          req_valid_next;
  logic          instr_valid_next;
  logic [31:0]   instr_out_next, instr_cia_next;

  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   cia_mem  [FIFO_DEPTH];

  logic          req_fire, rsp_ok, pop, taken, push;
  logic [31:0]   target;
  logic [CW:0]   credit_sum;

  assign target   = branch_nia & ~32'd3;
  assign req_fire = fetch_req_valid & fetch_req_ready;
  assign rsp_ok   = fetch_rsp_valid & (outstanding_reg != '0);
  assign pop      = instr_valid & instr_ready;
  assign taken    = branch_valid & branch_ready & branch_nia_valid;
  // Responses only enter the buffer while fetching and not being flushed this cycle.
  assign push     = rsp_ok & (state_reg == FETCH) & ~taken & ((count_reg != DEPTH_CNT) | pop);

  // Program counter and the address tag of the next word to be buffered.
  always_comb begin
    pc_next       = pc_reg;
    tail_cia_next = tail_cia_reg;
    if (taken) begin
      pc_next       = target;
      tail_cia_next = target;
    end else begin
      if (req_fire)
        pc_next = pc_reg + 32'd4;
      if (push)
        tail_cia_next = tail_cia_reg + 32'd4;
    end
  end

  always_comb begin
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_ok);
  end

  always_comb begin
    state_next = state_reg;
    drop_next  = drop_reg;
    if (taken) begin
      // Everything still in flight after this cycle belongs to the abandoned path.
      drop_next  = outstanding_next;
      state_next = (outstanding_next != '0) ? DRAIN : FETCH;
    end else if (state_reg == DRAIN && rsp_ok && drop_reg != '0) begin
      drop_next = drop_reg - CW'(1);
      if (drop_reg == CW'(1))
        state_next = FETCH;
    end
  end

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (taken) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (pop)
        rd_ptr_next = rd_ptr_reg + PW'(1);
      if (push)
        wr_ptr_next = wr_ptr_reg + PW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  // Next head of the buffer: either the word being written into an emptying buffer or a stored entry.
  always_comb begin
    instr_valid_next = (count_next != '0);
    instr_out_next   = instr_out;
    instr_cia_next   = instr_cia;
    if (count_next != '0) begin
      if (push && count_reg == CW'(pop)) begin
        instr_out_next = fetch_rsp_data;
        instr_cia_next = tail_cia_reg;
      end else begin
        instr_out_next = data_mem[rd_ptr_next];
        instr_cia_next = cia_mem[rd_ptr_next];
      end
    end
  end

  // In-flight requests plus buffered words never exceed the buffer, so responses always fit.
  always_comb begin
    credit_sum     = {1'b0, outstanding_next} + {1'b0, count_next};
    req_valid_next = (state_next == FETCH) && !taken && (credit_sum < DEPTH_SUM);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= fetch_rsp_data;
      cia_mem[wr_ptr_reg]  <= tail_cia_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_VECTOR;
      tail_cia_reg    <= RESET_VECTOR;
      outstanding_reg <= '0;
      drop_reg        <= '0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      fetch_req_valid <= 1'b0;
      instr_valid     <= 1'b0;
      instr_out       <= '0;
      instr_cia       <= '0;
      branch_ready    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      tail_cia_reg    <= tail_cia_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      fetch_req_valid <= req_valid_next;
      instr_valid     <= instr_valid_next;
      instr_out       <= instr_out_next;
      instr_cia       <= instr_cia_next;
      branch_ready    <= 1'b1;
    end
  end

  assign fetch_addr = pc_reg;

endmodule
